// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - central pipeline stall controller with multi-cycle EX sequencing and stall counter
module pipe_stall_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_mem,
  input  logic              ex_mc_start,
  input  logic [CNT_W-1:0]  ex_mc_cycles,
  input  logic              ex_flush,
  output logic [5:0]        stall,
  output logic              ex_mc_busy,
  output logic              ex_mc_done,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             mc_stall;
  logic             done_c;
  logic             busy_c;
  logic             n_long;
  logic [5:0]       stall_c;

  assign n_long = (ex_mc_cycles >= CNT_W'(2));

  // Hold decisions only happen where mc_stall is 0, so stall[3] reduces to stallreq_mem there.
  always_comb begin
    mc_stall = 1'b0;
    done_c   = 1'b0;
    busy_c   = 1'b0;
    state_n  = state;
    cnt_n    = cnt;
    case (state)
      S_IDLE: begin
        if (ex_mc_start) begin
          if (n_long) begin
            mc_stall = 1'b1;
            busy_c   = 1'b1;
            state_n  = S_BUSY;
            cnt_n    = ex_mc_cycles - CNT_W'(2);
          end else begin
            done_c  = 1'b1;
            state_n = stallreq_mem ? S_HOLD : S_IDLE;
          end
        end
      end
      S_BUSY: begin
        busy_c = 1'b1;
        if (cnt != '0) begin
          mc_stall = 1'b1;
          cnt_n    = cnt - CNT_W'(1);
        end else begin
          done_c  = 1'b1;
          state_n = stallreq_mem ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        if (!stallreq_mem) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (ex_flush) begin
      mc_stall = 1'b0;
      done_c   = 1'b0;
      busy_c   = (state == S_BUSY);
      state_n  = S_IDLE;
      cnt_n    = '0;
    end
  end

  always_comb begin
    stall_c = 6'b000000;
    if (stallreq_mem)     stall_c = 6'b011111;
    else if (mc_stall)    stall_c = 6'b001111;
    else if (stallreq_id) stall_c = 6'b000111;
  end

  assign stall      = rst ? 6'b000000 : stall_c;
  assign ex_mc_busy = ~rst & busy_c;
  assign ex_mc_done = ~rst & done_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (stall[0] && (perf_stall_cnt != {PERF_W{1'b1}})) begin
      perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
    end
  end

endmodule
